// File: rtl/decode_rename_queue_pkg.sv
// Shared decode/rename types and sizing constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package decode_rename_queue_pkg;

    localparam int DECODE_WIDTH              = 4;
    localparam int RENAME_WIDTH              = 4;
    localparam int DECODE_RENAME_QUEUE_DEPTH = 16;

    // One decoded instruction as handed from decode to rename.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [3:0]  uop_class;
        logic        excp;
    } decode_rename_pack_t;

endpackage

// File: rtl/decode_rename_queue_leading_ones.sv
// Counts contiguous ones starting at bit 0 (stops at the first zero).
// Latency: combinational.
// Backpressure: n/a.
module leading_ones_count #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]           vec,
    output logic [$clog2(WIDTH+1)-1:0] cnt
);

    localparam int CW = $clog2(WIDTH + 1);

    logic run;

    // Walk from lane 0 and stop counting at the first hole in the mask.
    always_comb begin
        cnt = '0;
        run = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            run = run & vec[i];
            if (run) cnt = CW'(i + 1);
        end
    end

endmodule

// File: rtl/decode_rename_queue.sv
// Multi-lane in-order queue between decode and rename; independent push/pop widths.
// Latency: a pushed pack appears on data_out the cycle after its push edge (no bypass).
// Backpressure: data_in_enable shows free slots at cycle start; a same-cycle pop never frees push lanes.
module decode_rename_queue
    import decode_rename_queue_pkg::*;
#(
    parameter int DEPTH      = DECODE_RENAME_QUEUE_DEPTH,
    parameter int PUSH_WIDTH = DECODE_WIDTH,
    parameter int POP_WIDTH  = RENAME_WIDTH,
    parameter int DATA_WIDTH = $bits(decode_rename_pack_t)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [PUSH_WIDTH*DATA_WIDTH-1:0] data_in,
    input  logic [PUSH_WIDTH-1:0]          data_in_valid,
    input  logic                           push,
    output logic [PUSH_WIDTH-1:0]          data_in_enable,
    output logic [POP_WIDTH*DATA_WIDTH-1:0] data_out,
    output logic [POP_WIDTH-1:0]           data_out_valid,
    input  logic [POP_WIDTH-1:0]           data_pop_valid,
    input  logic                           pop,
    input  logic                           flush,
    output logic [$clog2(DEPTH):0]         count,
    output logic                           full_add
);

    localparam int IW  = $clog2(DEPTH);
    localparam int PW  = IW + 1;
    localparam int HCW = $clog2(PUSH_WIDTH + 1);
    localparam int OCW = $clog2(POP_WIDTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [PW-1:0]         free_slots;
    logic [HCW-1:0]        push_run, n_push;
    logic [OCW-1:0]        pop_run, n_pop;
    logic [IW-1:0]         wr_idx [PUSH_WIDTH];
    logic [IW-1:0]         rd_idx [POP_WIDTH];

    // Lane masks and head data come from registered state only.
    always_comb begin
        free_slots     = PW'(DEPTH) - count;
        data_in_enable = '0;
        data_out_valid = '0;
        data_out       = '0;
        full_add       = (count == PW'(DEPTH));
        for (int i = 0; i < PUSH_WIDTH; i++) begin
            data_in_enable[i] = (int'(free_slots) > i);
            wr_idx[i]         = IW'(wr_ptr + PW'(i));
        end
        for (int i = 0; i < POP_WIDTH; i++) begin
            data_out_valid[i] = (int'(count) > i);
            rd_idx[i]         = IW'(rd_ptr + PW'(i));
            data_out[i*DATA_WIDTH +: DATA_WIDTH] = mem[rd_idx[i]];
        end
    end

    leading_ones_count #(.WIDTH(PUSH_WIDTH)) u_push_loc (
        .vec (data_in_valid & data_in_enable),
        .cnt (push_run)
    );

    leading_ones_count #(.WIDTH(POP_WIDTH)) u_pop_loc (
        .vec (data_pop_valid & data_out_valid),
        .cnt (pop_run)
    );

    // Only the leading contiguous run of granted lanes moves, and only on request.
    always_comb begin
        n_push = push ? push_run : '0;
        n_pop  = pop  ? pop_run  : '0;
    end

    // Storage is not reset; a flush makes any same-cycle write irrelevant, so skip it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PUSH_WIDTH; i++) begin
            if (!flush && (i < int'(n_push))) begin
                mem[wr_idx[i]] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Pointer/occupancy update; flush beats both push and pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(n_push);
            rd_ptr <= rd_ptr + PW'(n_pop);
            count  <= count + PW'(n_push) - PW'(n_pop);
        end
    end

endmodule

// File: tb/tb_decode_rename_queue.sv
// Directed bench for decode_rename_queue at DEPTH=8, PUSH_WIDTH=3, POP_WIDTH=2.
// Latency: checks sample 1ns after each rising edge.
// Backpressure: exercises full, empty, partial masks, wrap and flush.
module tb_decode_rename_queue;

    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic [3*DW-1:0] data_in;
    logic [2:0]    data_in_valid;
    logic          push;
    logic [2:0]    data_in_enable;
    logic [2*DW-1:0] data_out;
    logic [1:0]    data_out_valid;
    logic [1:0]    data_pop_valid;
    logic          pop;
    logic          flush;
    logic [3:0]    count;
    logic          full_add;

    int n_tests = 0;
    int n_fail  = 0;

    decode_rename_queue #(
        .DEPTH      (8),
        .PUSH_WIDTH (3),
        .POP_WIDTH  (2),
        .DATA_WIDTH (DW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .push           (push),
        .data_in_enable (data_in_enable),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_pop_valid (data_pop_valid),
        .pop            (pop),
        .flush          (flush),
        .count          (count),
        .full_add       (full_add)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic p, input logic [2:0] dv, input logic [31:0] d0,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic q, input logic [1:0] pv, input logic f);
        push           = p;
        data_in_valid  = dv;
        data_in        = {d2, d1, d0};
        pop            = q;
        data_pop_valid = pv;
        flush          = f;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [3:0] c, input logic [1:0] ov,
                             input logic [2:0] ie, input logic fa);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".out_valid"}, 32'(data_out_valid), 32'(ov));
        chk({tag, ".in_enable"}, 32'(data_in_enable), 32'(ie));
        chk({tag, ".full_add"}, 32'(full_add), 32'(fa));
    endtask

    task automatic chk_head(input string tag, input logic [31:0] h0, input logic [31:0] h1);
        chk({tag, ".lane0"}, data_out[31:0], h0);
        chk({tag, ".lane1"}, data_out[63:32], h1);
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 3'b000, 0, 0, 0, 0, 2'b00, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 4'd0, 2'b00, 3'b111, 1'b0);
        rst = 1'b1;

        // 1: build up count=5, then reset asynchronously mid-push
        drive(1, 3'b111, 32'h1, 32'h2, 32'h3, 0, 2'b00, 0);
        step();
        chk("t1.count3", 32'(count), 32'd3);
        drive(1, 3'b011, 32'h4, 32'h5, 32'h6, 0, 2'b00, 0);
        step();
        chk("t1.count5", 32'(count), 32'd5);
        drive(1, 3'b111, 32'h7, 32'h8, 32'h9, 0, 2'b00, 0);
        #2 rst = 1'b0;
        #1;
        chk_state("t1.async_rst", 4'd0, 2'b00, 3'b111, 1'b0);
        rst = 1'b1;
        drive(1, 3'b111, 32'h10, 32'h11, 32'h12, 0, 2'b00, 0);
        step();
        chk_state("t1.after_rst", 4'd3, 2'b11, 3'b111, 1'b0);
        chk_head("t1.head", 32'h10, 32'h11);

        // 2: fill; third push only gets two lanes
        drive(1, 3'b111, 32'h13, 32'h14, 32'h15, 0, 2'b00, 0);
        step();
        chk_state("t2.count6", 4'd6, 2'b11, 3'b011, 1'b0);
        drive(1, 3'b111, 32'h16, 32'h17, 32'h18, 0, 2'b00, 0);
        step();
        chk_state("t2.full", 4'd8, 2'b11, 3'b000, 1'b1);
        chk_head("t2.head", 32'h10, 32'h11);

        // 3: full + pop + push -> pop only
        drive(1, 3'b111, 32'h20, 32'h21, 32'h22, 1, 2'b11, 0);
        step();
        chk_state("t3", 4'd6, 2'b11, 3'b011, 1'b0);
        chk_head("t3.head", 32'h12, 32'h13);

        // 4: four pop-2/push-2 cycles crossing index 7->0
        drive(1, 3'b011, 32'h30, 32'h31, 32'h0, 1, 2'b11, 0);
        step();
        chk_head("t4.c1", 32'h14, 32'h15);
        drive(1, 3'b011, 32'h32, 32'h33, 32'h0, 1, 2'b11, 0);
        step();
        chk_head("t4.c2", 32'h16, 32'h17);
        drive(1, 3'b011, 32'h34, 32'h35, 32'h0, 1, 2'b11, 0);
        step();
        chk_head("t4.c3", 32'h30, 32'h31);
        drive(1, 3'b011, 32'h36, 32'h37, 32'h0, 1, 2'b11, 0);
        step();
        chk_head("t4.c4", 32'h32, 32'h33);
        chk("t4.count", 32'(count), 32'd6);

        // 5: drain with full and partial pop masks, then sparse push mask
        drive(0, 3'b000, 0, 0, 0, 1, 2'b11, 0);
        step();
        chk_head("t5.p1", 32'h34, 32'h35);
        step();
        chk_head("t5.p2", 32'h36, 32'h37);
        chk("t5.count2", 32'(count), 32'd2);
        drive(0, 3'b000, 0, 0, 0, 1, 2'b01, 0);
        step();
        chk_state("t5.count1", 4'd1, 2'b01, 3'b111, 1'b0);
        chk("t5.head37", data_out[31:0], 32'h37);
        drive(0, 3'b000, 0, 0, 0, 1, 2'b11, 0);
        step();
        chk_state("t5.empty", 4'd0, 2'b00, 3'b111, 1'b0);
        step();
        chk("t5.pop_empty", 32'(count), 32'd0);
        drive(1, 3'b101, 32'h40, 32'h41, 32'h42, 0, 2'b00, 0);
        step();
        chk_state("t5.push101", 4'd1, 2'b01, 3'b111, 1'b0);
        chk("t5.head40", data_out[31:0], 32'h40);
        drive(0, 3'b000, 0, 0, 0, 1, 2'b10, 0);
        step();
        chk("t5.pop10", 32'(count), 32'd1);

        // 6: flush with push and pop at count=4
        drive(1, 3'b111, 32'h50, 32'h51, 32'h52, 0, 2'b00, 0);
        step();
        chk("t6.count4", 32'(count), 32'd4);
        drive(1, 3'b111, 32'h60, 32'h61, 32'h62, 1, 2'b11, 1);
        step();
        chk_state("t6.flush", 4'd0, 2'b00, 3'b111, 1'b0);
        drive(1, 3'b011, 32'h70, 32'h71, 32'h0, 0, 2'b00, 0);
        step();
        chk("t6.refill", 32'(count), 32'd2);
        chk_head("t6.head", 32'h70, 32'h71);

        drive(0, 3'b000, 0, 0, 0, 0, 2'b00, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
